// File: rtl/rc4_keystream_gen.sv
// RC4 keystream engine: key buffer, S-box init, KSA, optional RC4-drop discard,
// then one keystream word per accepted valid/ready handshake.
module rc4_keystream_gen #(
  parameter int W       = 8,
  parameter int KEY_MAX = 16,
  parameter int DROP_N  = 0
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_n,
  input  logic                         start,
  input  logic [$clog2(KEY_MAX+1)-1:0] key_len,
  input  logic                         key_wr_en,
  input  logic [$clog2(KEY_MAX)-1:0]   key_wr_addr,
  input  logic [W-1:0]                 key_wr_data,
  output logic                         busy,
  output logic                         ks_valid,
  input  logic                         ks_ready,
  output logic [W-1:0]                 ks_data
);

  localparam int N   = 2**W;
  localparam int LW  = $clog2(KEY_MAX+1);
  localparam int KAW = $clog2(KEY_MAX);
  localparam int DW  = (DROP_N > 1) ? $clog2(DROP_N) : 1;

  localparam logic [W-1:0]  I_LAST    = {W{1'b1}};
  localparam logic [LW-1:0] LEN_MAX   = LW'(KEY_MAX);
  localparam logic [DW-1:0] DROP_LAST = DW'((DROP_N > 0) ? DROP_N - 1 : 0);

  typedef enum logic [2:0] {IDLE, INIT, KSA, DROP, GEN} state_t;
  state_t state, state_nxt;

  logic [W-1:0]  s_box   [N];
  logic [W-1:0]  key_buf [KEY_MAX];
  logic [W-1:0]  i_q, j_q;
  logic [LW-1:0] len_q, kidx_q, kidx_nxt, len_eff;
  logic [DW-1:0] drop_cnt;

  logic [W-1:0]  ksa_si, ksa_j, ksa_sj;
  logic [W-1:0]  p_i, p_si, p_j, p_sj, p_t, p_out;
  logic          prga_step;

  // Zero or oversize lengths fall back to the full buffer.
  assign len_eff  = (key_len == '0 || key_len > LEN_MAX) ? LEN_MAX : key_len;
  assign kidx_nxt = (kidx_q == len_q - LW'(1)) ? '0 : kidx_q + LW'(1);

  assign ksa_si = s_box[i_q];
  assign ksa_j  = j_q + ksa_si + key_buf[kidx_q[KAW-1:0]];
  assign ksa_sj = s_box[ksa_j];

  // Output index is resolved against the post-swap array by forwarding.
  assign p_i   = i_q + W'(1);
  assign p_si  = s_box[p_i];
  assign p_j   = j_q + p_si;
  assign p_sj  = s_box[p_j];
  assign p_t   = p_si + p_sj;
  assign p_out = (p_t == p_i) ? p_sj : (p_t == p_j) ? p_si : s_box[p_t];

  assign prga_step = (state == DROP) || (state == GEN && (!ks_valid || ks_ready));

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = INIT;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        INIT:    if (i_q == I_LAST) state_nxt = KSA;
        KSA:     if (i_q == I_LAST) state_nxt = (DROP_N > 0) ? DROP : GEN;
        DROP:    if (drop_cnt == DROP_LAST) state_nxt = GEN;
        GEN:     state_nxt = GEN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state == INIT) || (state == KSA) || (state == DROP);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      i_q      <= '0;
      j_q      <= '0;
      len_q    <= LEN_MAX;
      kidx_q   <= '0;
      drop_cnt <= '0;
      ks_valid <= 1'b0;
      ks_data  <= '0;
    end else if (start) begin
      i_q      <= '0;
      j_q      <= '0;
      len_q    <= len_eff;
      kidx_q   <= '0;
      drop_cnt <= '0;
      ks_valid <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          i_q    <= i_q + W'(1);
          j_q    <= '0;
          kidx_q <= '0;
        end
        KSA: begin
          i_q    <= i_q + W'(1);
          j_q    <= (i_q == I_LAST) ? '0 : ksa_j;
          kidx_q <= kidx_nxt;
        end
        DROP: begin
          i_q      <= p_i;
          j_q      <= p_j;
          drop_cnt <= drop_cnt + DW'(1);
        end
        GEN: begin
          if (prga_step) begin
            i_q      <= p_i;
            j_q      <= p_j;
            ks_data  <= p_out;
            ks_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage arrays carry no reset; their contents are rebuilt on every start.
  always_ff @(posedge wb_clk_i) begin
    if (key_wr_en && (state == IDLE || state == GEN))
      key_buf[key_wr_addr] <= key_wr_data;
    if (!start) begin
      case (state)
        INIT: s_box[i_q] <= i_q;
        KSA: begin
          s_box[i_q]   <= ksa_sj;
          s_box[ksa_j] <= ksa_si;
        end
        default: begin
          if (prga_step) begin
            s_box[p_i] <= p_sj;
            s_box[p_j] <= p_si;
          end
        end
      endcase
    end
  end

endmodule
